// File: rtl/rot_host_if.sv
// Host-side sequencer for the rotate unit: accepts a request, issues one start
// pulse, waits for ready (with a watchdog) and hands the captured z back upstream.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | req_ready=1, waiting for a host request
// ISSUE   | start=1 for one cycle, wait counter cleared
// WAIT_LO | waiting for ready=0 so a stale ready is never captured
// WAIT_HI | waiting for ready=1 to capture z
// RESP    | resp_valid=1, holding result until resp_ready
module rot_host_if #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_data,
  input  logic [1:0] req_rot,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [3:0] resp_data,
  output logic       resp_err,
  output logic       start,
  output logic       a,
  output logic       b,
  output logic [3:0] x,
  input  logic       ready,
  input  logic [3:0] z
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RESP
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [3:0] x_q, x_d;
  logic       resp_valid_q, resp_valid_d;
  logic [3:0] resp_data_q, resp_data_d;
  logic       resp_err_q, resp_err_d;
  logic [7:0] cnt_q, cnt_d;

  logic       capture;
  logic       expired;

  // Capture wins over an expiry on the same edge.
  assign capture = (state_q == S_WAIT_HI) && ready;
  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    a_d          = a_q;
    b_d          = b_q;
    x_d          = x_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_rot == 2'd3) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 4'd0;
          end else begin
            // rot 0 -> (0,1), 1 -> (1,0), 2 -> (1,1); (0,0) would stall the unit
            a_d     = (req_rot != 2'd0);
            b_d     = (req_rot != 2'd1);
            x_d     = req_data;
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT_LO;
      end

      S_WAIT_LO, S_WAIT_HI: begin
        if (capture) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = z;
        end else if (expired) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (state_q == S_WAIT_LO && !ready) begin
            state_d = S_WAIT_HI;
          end
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      a_q          <= 1'b0;
      b_q          <= 1'b1;
      x_q          <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 4'd0;
      resp_err_q   <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      a_q          <= a_d;
      b_q          <= b_d;
      x_q          <= x_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign start      = start_q;
  assign a          = a_q;
  assign b          = b_q;
  assign x          = x_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_rot_host_if.sv
// Bench for rot_host_if: behavioural rotate-unit model plus a latency/result
// reference model, directed cases followed by randomized transactions.
module tb_rot_host_if;

  localparam int TO = 16;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_data;
  logic [1:0] req_rot;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_data;
  logic       resp_err;
  logic       start;
  logic       a;
  logic       b;
  logic [3:0] x;
  logic       ready;
  wire  [3:0] z;

  int n_checks = 0;
  int n_err    = 0;
  int start_cnt = 0;

  rot_host_if #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_rot    (req_rot),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .start      (start),
    .a          (a),
    .b          (b),
    .x          (x),
    .ready      (ready),
    .z          (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate unit model: ready pulses (1 + rot + extra) edges after it sees start.
  bit         unit_dead  = 1'b0;
  int         unit_extra = 0;
  logic       u_ready;
  logic [3:0] u_x;
  int         u_rot;
  int         u_cnt;
  logic [3:0] u_res;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_ready <= 1'b0;
      u_cnt   <= 0;
      u_x     <= 4'd0;
      u_rot   <= 0;
    end else begin
      u_ready <= 1'b0;
      if (start && !unit_dead) begin
        u_x   <= x;
        u_rot <= ({a, b} == 2'b01) ? 0 : ({a, b} == 2'b10) ? 1 : 2;
        u_cnt <= 1 + (({a, b} == 2'b01) ? 0 : ({a, b} == 2'b10) ? 1 : 2) + unit_extra;
      end else if (u_cnt > 0) begin
        u_cnt <= u_cnt - 1;
        if (u_cnt == 1) u_ready <= 1'b1;
      end
    end
  end

  always_comb begin
    u_res = 4'd0;
    for (int i = 0; i < 4; i++) u_res[i] = u_x[(i + u_rot) % 4];
  end

  assign ready = u_ready;
  assign z     = u_ready ? u_res : 4'bzzzz;

  always @(posedge clk) if (start === 1'b1) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rotr(input int d, input int r);
    return 4'(((d >> r) | (d << (4 - r))) & 15);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"},      start,      0);
    chk({tag, "_a"},          a,          0);
    chk({tag, "_b"},          b,          1);
    chk({tag, "_x"},          x,          0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"},  resp_data,  0);
    chk({tag, "_resp_err"},   resp_err,   0);
  endtask

  // One full transaction; expectations come from the rules, not from the DUT.
  task automatic txn(input logic [3:0] d, input logic [1:0] r, input int stall,
                     input bit dead, input int extra);
    int         exp_lat;
    logic [3:0] exp_d;
    bit         exp_e;
    int         cap_edge;
    int         s0;
    int         lat;
    logic [1:0] exp_ab;
    exp_ab = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b11;
    cap_edge = 3 + r + extra;
    if (r == 3) begin
      exp_lat = 1; exp_e = 1'b1; exp_d = 4'd0;
    end else if (dead || cap_edge > TO + 1) begin
      exp_lat = TO + 2; exp_e = 1'b1; exp_d = 4'd0;
    end else begin
      exp_lat = cap_edge + 1; exp_e = 1'b0; exp_d = rotr(d, r);
    end
    unit_dead  = dead;
    unit_extra = extra;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_data   = d;
    req_rot    = r;
    resp_ready = (stall == 0);
    s0 = start_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = 4'($urandom);
    req_rot   = 2'($urandom);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < TO + 10) begin
      chk("start_pulse", start, (lat == 1) ? 1 : 0);
      chk("req_ready_busy", req_ready, 0);
      chk("x_hold", x, d);
      chk("ab_hold", {a, b}, exp_ab);
      @(negedge clk);
      lat++;
    end
    chk("resp_valid", resp_valid, 1);
    chk("latency", lat, exp_lat);
    chk("resp_data", resp_data, exp_d);
    chk("resp_err", resp_err, exp_e);
    chk("start_count", start_cnt - s0, (r == 3) ? 0 : 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1);
      chk("stall_data", resp_data, exp_d);
      chk("stall_err", resp_err, exp_e);
      chk("stall_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", resp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    resp_ready = 1'b0;
    unit_dead  = 1'b0;
    unit_extra = 0;
  endtask

  initial begin
    int seen_valid;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_data   = 4'd0;
    req_rot    = 2'd0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_reset");
    chk("after_reset_req_ready", req_ready, 1);

    txn(4'b1011, 2'd0, 0, 1'b0, 0);
    txn(4'b1011, 2'd1, 0, 1'b0, 0);
    txn(4'b1101, 2'd2, 0, 1'b0, 0);
    txn(4'b1111, 2'd3, 0, 1'b0, 0);
    txn(4'b0110, 2'd1, 0, 1'b1, 0);
    txn(4'b0110, 2'd1, 0, 1'b0, 0);
    txn(4'b1001, 2'd0, 5, 1'b0, 0);
    txn(4'b0011, 2'd0, 0, 1'b0, 14);
    txn(4'b0011, 2'd0, 0, 1'b0, 15);
    txn(4'b0101, 2'd2, 0, 1'b0, 0);

    // Reset while waiting for ready: response must be dropped.
    @(negedge clk);
    req_valid = 1'b1; req_data = 4'b1100; req_rot = 2'd2; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen_valid++;
    end
    chk("mid_reset_no_resp", seen_valid, 0);
    resp_ready = 1'b0;
    txn(4'b1011, 2'd0, 0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      txn(4'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          1'b0, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/rot_host_if.md
# rot_host_if

Initiator-side sequencer for the rotate datapath's start/ready command interface. It accepts rotate requests from an upstream host over a valid/ready handshake and drives `start`, `a`, `b` and `x` to the rotate unit. It then waits for the unit's `ready`, captures the tri-stated `z` bus and returns the result upstream with its own valid/ready handshake. It also carries a timeout watchdog and rejects illegal rotate codes.

## Interface
- `TIMEOUT`, default 16: maximum number of wait cycles for the unit's ready pulse before the request is aborted. Legal range is 4..255.
- `clk`  in  1  system clock. The rotate unit runs on the same clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  host request valid.
- `req_ready`  out  1  request accepted on any edge where `req_valid` and `req_ready` are both 1.
- `req_data`  in  4  operand word.
- `req_rot`  in  2  rotate-right amount: 0, 1, 2. Value 3 is illegal.
- `resp_valid`  out  1  result valid.
- `resp_ready`  in  1  host accepts the result.
- `resp_data`  out  4  captured `z` word.
- `resp_err`  out  1  set for an illegal code or a timeout.
- `start`  out  1  command strobe to the rotate unit.
- `a`, `b`  out  1 each  rotate selects.
- `x`  out  4  operand to the rotate unit.
- `ready`  in  1  unit done flag.
- `z`  in  4  unit result. Valid only while `ready`=1, high-Z otherwise.

## Operation
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, RESP.
- **IDLE**
  - `req_ready`=1; it is 0 in every other state.
  - On a handshake, latch `req_data` into `x` and encode `req_rot` onto `a`/`b`: 0→(a=0,b=1), 1→(1,0), 2→(1,1).
  - `req_rot`=3: do not touch the unit. Go directly to RESP with `resp_err`=1 and `resp_data`=0.
  - Legal code: go to ISSUE.
- **ISSUE**
  - `start`=1 for exactly this one cycle.
  - Clear the wait counter.
  - Go to WAIT_LO.
- **WAIT_LO**
  - Wait for `ready`=0 so a stale ready from a previous transaction is never captured.
  - On `ready`=0, go to WAIT_HI.
- **WAIT_HI**
  - On an edge with `ready`=1, capture `z` into `resp_data`, set `resp_err`=0 and go to RESP.
- **Wait counter**
  - Increments every cycle spent in WAIT_LO or WAIT_HI.
  - If it reaches `TIMEOUT` without a capture, go to RESP with `resp_err`=1 and `resp_data`=0.
- **RESP**
  - `resp_valid`=1.
  - `resp_data` and `resp_err` are held stable until `resp_ready`=1. Then return to IDLE.
- **Drive rules**
  - `x`, `a` and `b` are held constant from ISSUE through the capture or timeout edge, because the unit samples `a`/`b` in several of its internal steps.
  - Code (a=0,b=0) is never driven. It stalls the unit.
  - In IDLE, `a`/`b`/`x` keep their last values.
- **Start timing:** `start` is asserted only in ISSUE. It is never asserted while `ready`=1 is being captured, so the unit returns to idle after each transaction.
- **Error response:** an error response must not leave the unit mid-command on a legal-code path. After a timeout, the next request still goes through WAIT_LO, which guards against a late `ready`.

## Timing
- All outputs are registered except `req_ready`, which is decoded from the state.
- **Reset values:** state=IDLE, `start`=0, `a`=0, `b`=1, `x`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0, counter=0. `req_ready`=1 once reset is released.
- **Latency**, counted from the request-accept edge (edge 0) to the first cycle with `resp_valid`=1, against a correctly behaving unit:
  - rot 0: 4 cycles.
  - rot 1: 5 cycles.
  - rot 2: 6 cycles.
  - Illegal code: 1 cycle.
- **Throughput:** one transaction in flight. The next request can be accepted in the cycle after the RESP handshake.
- **Simultaneous events:** in WAIT_HI, a `ready`=1 edge that coincides with the counter reaching `TIMEOUT` is a capture, not a timeout.
- **Mid-operation reset:** `rst` low in any state forces all reset values immediately (asynchronous). Any pending response is discarded.
- **`z` sampling:** `z` is sampled only on an edge where `ready`=1. X/Z on `z` at any other time must not propagate to `resp_data`.

## Test plan
- rot 0, `req_data`=1011, `resp_ready`=1 → one `start` pulse; `resp_valid` 4 cycles after accept; `resp_data`=1011, `resp_err`=0.
- rot 1, data 1011 → `resp_data`=1101, latency 5. Then rot 2, data 1101 → `resp_data`=0111, latency 6.
- `req_rot`=3, data 1111 → `start` never asserted; `resp_valid` 1 cycle after accept with `resp_err`=1, `resp_data`=0.
- Unit model holds `ready`=0 forever, `TIMEOUT`=16 → `resp_err`=1, `resp_data`=0 after 16 wait cycles. A following legal request then completes normally once the model recovers.
- `resp_ready` held 0 for 5 cycles with a result pending → `resp_valid`, `resp_data` and `resp_err` stay stable; `req_ready`=0 throughout; completes on release.
- Assert `rst`=0 during WAIT_HI → outputs go to their reset values immediately; `resp_valid` is never asserted; a new request after release behaves as the first case.
